// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer in front of fft_top.
// Captures one frame of ADC samples bank-major into the four input banks,
// pulses the FFT start, waits for completion, then streams all N result bins.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for iARM; cnt held at zero
// S_LOAD  | accepting samples, one RAM write per accepted sample
// S_START | one-cycle FFT start pulse; arms the completion watchdog
// S_WAIT  | waiting for a low-then-high iFFT_RDY, or watchdog expiry
// S_DUMP  | issuing N read addresses and draining the read pipeline
module fft_frame_ctrl #(
  parameter int A_BIT   = 10,
  parameter int D_BIT   = 17,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 65536
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iARM,
  input  logic [D_BIT-2:0] iADC_DATA,
  input  logic             iADC_VALID,
  output logic             oADC_READY,
  output logic [D_BIT-2:0] oDATA,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic             oFFT_START,
  input  logic             iFFT_RDY,
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iFFT_RE_0,
  input  logic [D_BIT-1:0] iFFT_RE_1,
  input  logic [D_BIT-1:0] iFFT_RE_2,
  input  logic [D_BIT-1:0] iFFT_RE_3,
  output logic [D_BIT-1:0] oOUT_DATA,
  output logic             oOUT_VALID,
  output logic             oOUT_LAST,
  output logic             oBUSY,
  output logic             oOVF,
  output logic             oERR
);

  localparam int CW = A_BIT + 2;
  localparam int TW = $clog2(TIMEOUT + 1);
  // all-ones is sample/bin N-1, the terminal count for both LOAD and DUMP
  localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
  // watchdog is a down-counter; reaching zero means TIMEOUT WAIT cycles elapsed
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DUMP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [TW-1:0]        tmr;
  logic                 seen_low;
  logic                 rd_act;
  logic                 issue;
  logic [RD_LAT:0]      vld_pipe;
  logic [RD_LAT:0]      last_pipe;
  logic [RD_LAT:0][1:0] bank_pipe;

  assign issue = (state == S_DUMP) && rd_act;

  // Frame sequencing FSM with registered write-side and status outputs
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tmr        <= '0;
      seen_low   <= 1'b0;
      rd_act     <= 1'b0;
      oADC_READY <= 1'b0;
      oDATA      <= '0;
      oADDR_WR   <= '0;
      oWE        <= '0;
      oFFT_START <= 1'b0;
      oADDR_RD   <= '0;
      oBUSY      <= 1'b0;
      oOVF       <= 1'b0;
      oERR       <= 1'b0;
    end else begin
      oWE        <= '0;
      oFFT_START <= 1'b0;
      // samples outside LOAD are dropped but flagged
      if (iADC_VALID && (state != S_LOAD)) oOVF <= 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (iARM) begin
            state      <= S_LOAD;
            oADC_READY <= 1'b1;
            oBUSY      <= 1'b1;
            // a sample coincident with iARM is still outside LOAD
            oOVF       <= iADC_VALID;
            oERR       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (iADC_VALID) begin
            oWE      <= 4'b0001 << cnt[CW-1:A_BIT];
            oADDR_WR <= cnt[A_BIT-1:0];
            oDATA    <= iADC_DATA;
            cnt      <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              state      <= S_START;
              oADC_READY <= 1'b0;
            end
          end
        end
        S_START: begin
          oFFT_START <= 1'b1;
          seen_low   <= 1'b0;
          tmr        <= TMR_LOAD;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (!iFFT_RDY) seen_low <= 1'b1;
          // RDY takes priority over a coincident watchdog expiry
          if (iFFT_RDY && seen_low) begin
            state  <= S_DUMP;
            cnt    <= '0;
            rd_act <= 1'b1;
          end else if (tmr == '0) begin
            state <= S_IDLE;
            oBUSY <= 1'b0;
            oERR  <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_DUMP: begin
          if (rd_act) begin
            oADDR_RD <= cnt[A_BIT-1:0];
            cnt      <= cnt + CW'(1);
            if (cnt == CNT_LAST) rd_act <= 1'b0;
          end
          if (last_pipe[RD_LAT]) begin
            state <= S_IDLE;
            oBUSY <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read pipeline: bank index follows the address for RD_LAT cycles, then muxes the bank data
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      vld_pipe   <= '0;
      last_pipe  <= '0;
      bank_pipe  <= '0;
      oOUT_DATA  <= '0;
      oOUT_VALID <= 1'b0;
      oOUT_LAST  <= 1'b0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue && (cnt == CNT_LAST);
      bank_pipe[0] <= cnt[CW-1:A_BIT];
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
        bank_pipe[i] <= bank_pipe[i-1];
      end
      oOUT_VALID <= vld_pipe[RD_LAT];
      oOUT_LAST  <= last_pipe[RD_LAT];
      if (vld_pipe[RD_LAT]) begin
        case (bank_pipe[RD_LAT])
          2'd0:    oOUT_DATA <= iFFT_RE_0;
          2'd1:    oOUT_DATA <= iFFT_RE_1;
          2'd2:    oOUT_DATA <= iFFT_RE_2;
          default: oOUT_DATA <= iFFT_RE_3;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl: N=16 frames, stale RDY, throttled load,
// overflow, watchdog timeout and mid-LOAD reset, against a cycle-indexed
// expectation timeline plus a few hand-computed literal checks.
module tb_fft_frame_ctrl;
  localparam int A_BIT   = 2;
  localparam int D_BIT   = 17;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 20;
  localparam int NB      = 4;
  localparam int N       = 16;
  localparam int MAXC    = 400;
  localparam int M_BUSY = 0, M_READY = 1, M_OVF = 2, M_ERR = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             iARM = 1'b0;
  logic [D_BIT-2:0] iADC_DATA = '0;
  logic             iADC_VALID = 1'b0;
  logic             iFFT_RDY = 1'b1;
  logic             oADC_READY, oFFT_START, oOUT_VALID, oOUT_LAST, oBUSY, oOVF, oERR;
  logic [D_BIT-2:0] oDATA;
  logic [A_BIT-1:0] oADDR_WR, oADDR_RD;
  logic [3:0]       oWE;
  logic [D_BIT-1:0] re0, re1, re2, re3, oOUT_DATA;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // expectation timeline, indexed by cycle
  logic [3:0]  e_we [MAXC];
  logic [1:0]  e_wa [MAXC];
  logic [15:0] e_wd [MAXC];
  logic        e_start [MAXC];
  logic        e_ready [MAXC];
  logic        e_busy [MAXC];
  logic        e_ovf [MAXC];
  logic        e_err [MAXC];
  logic        e_rav [MAXC];
  logic [1:0]  e_ra [MAXC];
  logic        e_ov [MAXC];
  logic [16:0] e_od [MAXC];
  logic        e_ol [MAXC];

  // observations
  logic [15:0] ram [NB][NB];
  logic [16:0] out_q [$];
  logic [16:0] last_data = '0;
  int          n_last = 0;
  int          st_cyc = 0;

  fft_frame_ctrl #(.A_BIT(A_BIT), .D_BIT(D_BIT), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .iCLK(clk), .iRESET(rst), .iARM(iARM), .iADC_DATA(iADC_DATA), .iADC_VALID(iADC_VALID),
    .oADC_READY(oADC_READY), .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE(oWE),
    .oFFT_START(oFFT_START), .iFFT_RDY(iFFT_RDY), .oADDR_RD(oADDR_RD),
    .iFFT_RE_0(re0), .iFFT_RE_1(re1), .iFFT_RE_2(re2), .iFFT_RE_3(re3),
    .oOUT_DATA(oOUT_DATA), .oOUT_VALID(oOUT_VALID), .oOUT_LAST(oOUT_LAST),
    .oBUSY(oBUSY), .oOVF(oOVF), .oERR(oERR)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // fft_top stand-in: bank b holds 100*b+a, read latency RD_LAT=2
  logic [A_BIT-1:0] ad1 = '0, ad2 = '0;
  always @(posedge clk) begin
    ad1 <= oADDR_RD;
    ad2 <= ad1;
  end
  assign re0 = 17'(ad2);
  assign re1 = 17'd100 + 17'(ad2);
  assign re2 = 17'd200 + 17'(ad2);
  assign re3 = 17'd300 + 17'(ad2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark(input int sel, input int from, input logic val);
    for (int i = from; i < MAXC; i++)
      case (sel)
        M_BUSY:  e_busy[i]  = val;
        M_READY: e_ready[i] = val;
        M_OVF:   e_ovf[i]   = val;
        default: e_err[i]   = val;
      endcase
  endtask

  task automatic exp_write(input int cy, input int k, input logic [15:0] d);
    e_we[cy] = 4'(1 << (k / NB));
    e_wa[cy] = 2'(k % NB);
    e_wd[cy] = d;
  endtask

  // RDY accepted in cycle r: addresses from r+2, bins from r+5, last at r+20
  task automatic exp_dump(input int r);
    for (int k = 0; k < N; k++) begin
      e_rav[r+2+k] = 1'b1;
      e_ra[r+2+k]  = 2'(k % NB);
      e_ov[r+5+k]  = 1'b1;
      e_od[r+5+k]  = 17'(100 * (k / NB) + k % NB);
    end
    e_ol[r+5+N-1] = 1'b1;
    mark(M_BUSY, r + 5 + N - 1, 1'b0);
  endtask

  task automatic arm(input logic v, output int c);
    c = cyc;
    iARM = 1'b1;
    iADC_VALID = v;
    iADC_DATA = 16'h7777;
    mark(M_BUSY, c + 1, 1'b1);
    mark(M_READY, c + 1, 1'b1);
    mark(M_OVF, c + 1, v);
    mark(M_ERR, c + 1, 1'b0);
    tick();
    iARM = 1'b0;
    iADC_VALID = 1'b0;
  endtask

  // one frame of N samples, one valid every 'stride' cycles; v = cycle of last valid
  task automatic load(input int stride, input logic [15:0] dbase, output int v);
    v = 0;
    for (int k = 0; k < N; k++) begin
      iADC_VALID = 1'b1;
      iADC_DATA = dbase | 16'(k);
      exp_write(cyc + 1, k, dbase | 16'(k));
      if (k == N - 1) begin
        v = cyc;
        mark(M_READY, cyc + 1, 1'b0);
        e_start[cyc + 2] = 1'b1;
      end
      tick();
      iADC_VALID = 1'b0;
      for (int g = 1; g < stride; g++) begin
        if (k == 5 && g == 1) iARM = 1'b1;
        tick();
        iARM = 1'b0;
      end
    end
  endtask

  task automatic clear_ram();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < NB; a++) ram[b][a] = 16'hFFFF;
  endtask

  // per-cycle compare against the timeline, plus observation capture
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("we", 32'(oWE), 32'(e_we[cyc]));
      if (e_we[cyc] != 4'd0) begin
        chk("addr_wr", 32'(oADDR_WR), 32'(e_wa[cyc]));
        chk("wr_data", 32'(oDATA), 32'(e_wd[cyc]));
      end
      chk("fft_start", 32'(oFFT_START), 32'(e_start[cyc]));
      chk("adc_ready", 32'(oADC_READY), 32'(e_ready[cyc]));
      chk("busy", 32'(oBUSY), 32'(e_busy[cyc]));
      chk("ovf", 32'(oOVF), 32'(e_ovf[cyc]));
      chk("err", 32'(oERR), 32'(e_err[cyc]));
      chk("out_valid", 32'(oOUT_VALID), 32'(e_ov[cyc]));
      chk("out_last", 32'(oOUT_LAST), 32'(e_ol[cyc]));
      if (e_ov[cyc]) chk("out_data", 32'(oOUT_DATA), 32'(e_od[cyc]));
      if (e_rav[cyc]) chk("addr_rd", 32'(oADDR_RD), 32'(e_ra[cyc]));
      for (int b = 0; b < NB; b++)
        if (oWE[b]) ram[b][oADDR_WR] = oDATA;
      if (oOUT_VALID) out_q.push_back(oOUT_DATA);
      if (oOUT_LAST) begin
        last_data = oOUT_DATA;
        n_last++;
      end
      if (oFFT_START) st_cyc = cyc;
    end
  end

  initial begin
    int c, v, s, r, rr;
    for (int i = 0; i < MAXC; i++) begin
      e_we[i] = '0; e_wa[i] = '0; e_wd[i] = '0; e_start[i] = 1'b0;
      e_ready[i] = 1'b0; e_busy[i] = 1'b0; e_ovf[i] = 1'b0; e_err[i] = 1'b0;
      e_rav[i] = 1'b0; e_ra[i] = '0; e_ov[i] = 1'b0; e_od[i] = '0; e_ol[i] = 1'b0;
    end
    clear_ram();
    tick();
    tick();
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_we", 32'(oWE), 32'd0);
    chk("rst_out_valid", 32'(oOUT_VALID), 32'd0);
    chk("rst_ovf", 32'(oOVF), 32'd0);
    rst = 1'b0;
    tick();
    tick();

    // frame A: continuous load, stale RDY held through START, 5-cycle low, then rise
    arm(1'b0, c);
    load(1, 16'h0000, v);
    tick();
    tick();
    iFFT_RDY = 1'b0;
    repeat (5) tick();
    iFFT_RDY = 1'b1;
    r = cyc;
    exp_dump(r);
    while (cyc < r + 23) tick();
    iFFT_RDY = 1'b0;
    chk("A_start_latency", 32'(st_cyc - v), 32'd2);
    chk("A_ram_b1a0", 32'(ram[1][0]), 32'd4);
    chk("A_ram_b3a3", 32'(ram[3][3]), 32'd15);
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < NB; a++) chk("A_ram", 32'(ram[b][a]), 32'(NB * b + a));
    chk("A_out_count", 32'(out_q.size()), 32'd16);
    chk("A_out_4", 32'(out_q[4]), 32'd100);
    chk("A_last_data", 32'(last_data), 32'd303);

    // valid while idle: sticky overflow until the next iARM
    tick();
    iADC_VALID = 1'b1;
    mark(M_OVF, cyc + 1, 1'b1);
    tick();
    iADC_VALID = 1'b0;
    repeat (4) tick();
    chk("idle_ovf", 32'(oOVF), 32'd1);

    // frame B: valid every 3rd cycle (stray iARM mid-load), RDY never rises -> timeout
    clear_ram();
    arm(1'b0, c);
    load(3, 16'h0000, v);
    s = v + 2;
    mark(M_BUSY, s + TIMEOUT, 1'b0);
    mark(M_ERR, s + TIMEOUT, 1'b1);
    while (cyc < s + TIMEOUT + 2) tick();
    chk("B_err", 32'(oERR), 32'd1);
    chk("B_busy", 32'(oBUSY), 32'd0);
    chk("B_ram_b2a3", 32'(ram[2][3]), 32'd11);
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < NB; a++) chk("B_ram", 32'(ram[b][a]), 32'(NB * b + a));

    // frame C: valid coincident with iARM, 7 samples, then async reset mid-LOAD
    arm(1'b1, c);
    for (int k = 0; k < 7; k++) begin
      iADC_VALID = 1'b1;
      iADC_DATA = 16'h0100 | 16'(k);
      if (k < 6) exp_write(cyc + 1, k, 16'h0100 | 16'(k));
      tick();
    end
    iADC_VALID = 1'b0;
    rr = cyc;
    mark(M_BUSY, rr, 1'b0);
    mark(M_READY, rr, 1'b0);
    mark(M_OVF, rr, 1'b0);
    mark(M_ERR, rr, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("C_rst_we", 32'(oWE), 32'd0);
    chk("C_rst_busy", 32'(oBUSY), 32'd0);
    chk("C_rst_ready", 32'(oADC_READY), 32'd0);
    chk("C_rst_ovf", 32'(oOVF), 32'd0);
    chk("C_rst_data", 32'(oDATA), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // frame D: fresh frame after reset, negative samples, RDY rises 3 cycles into WAIT
    out_q.delete();
    arm(1'b0, c);
    load(1, 16'h8000, v);
    s = v + 2;
    while (cyc < s + 3) tick();
    iFFT_RDY = 1'b1;
    r = cyc;
    exp_dump(r);
    while (cyc < r + 23) tick();
    iFFT_RDY = 1'b0;
    chk("D_ram_b2a1", 32'(ram[2][1]), 32'h8009);
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < NB; a++) chk("D_ram", 32'(ram[b][a]), 32'(16'h8000 | 16'(NB * b + a)));
    chk("D_out_count", 32'(out_q.size()), 32'd16);
    chk("D_out_15", 32'(out_q[15]), 32'd303);
    chk("last_count", 32'(n_last), 32'd2);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for `fft_top`. It accepts a stream of ADC samples and writes them bank-major into the four input RAM banks. Once a frame is complete it pulses the FFT start, waits for completion, then reads all N result bins out as a serial stream. It sits between the ADC front end and `fft_top`, replacing the per-bank write-address and write-enable driving that is currently done by hand.

## Interface
- `A_BIT`, 10: bank address width; N_bank = 2^A_BIT, N = 4·N_bank (default 4096).
- `D_BIT`, 17: FFT internal data width; ADC samples are D_BIT-1 bits signed.
- `RD_LAT`, 2: `fft_top` read latency in cycles, from `oADDR_RD` to `iFFT_RE_x`.
- `TIMEOUT`, 65536: maximum WAIT cycles before an error is flagged.

Ports (all outputs registered):
- `iCLK`, in, 1: clock.
- `iRESET`, in, 1: reset; one clock; reset is asynchronous and active-high.
- `iARM`, in, 1: single-cycle request to capture one frame.
- `iADC_DATA`, in, D_BIT-1: signed sample.
- `iADC_VALID`, in, 1: sample strobe.
- `oADC_READY`, out, 1: high in LOAD.
- `oDATA`, out, D_BIT-1: write data to `fft_top` `iDATA`.
- `oADDR_WR`, out, A_BIT: write address, shared by all four banks.
- `oWE`, out, 4: one-hot bank write enable.
- `oFFT_START`, out, 1: one-cycle start pulse.
- `iFFT_RDY`, in, 1: `fft_top` `oRDY`.
- `oADDR_RD`, out, A_BIT: read address, shared by all four banks.
- `iFFT_RE_0`..`iFFT_RE_3`, in, D_BIT each: bank read data.
- `oOUT_DATA`, out, D_BIT: result bin.
- `oOUT_VALID`, out, 1: result strobe.
- `oOUT_LAST`, out, 1: marks bin N-1.
- `oBUSY`, out, 1: state ≠ IDLE.
- `oOVF`, out, 1: sticky; a sample arrived outside LOAD.
- `oERR`, out, 1: sticky; WAIT timed out.

## Operation
- Five states: IDLE, LOAD, START, WAIT, DUMP. A single counter `cnt` of A_BIT+2 bits is shared by LOAD and DUMP.
- **IDLE**
  - `iARM`=1 → LOAD.
  - Clears `cnt`, `oOVF` and `oERR`.
- **LOAD**
  - `oADC_READY`=1.
  - On each `iADC_VALID`=1, the next cycle drives:
    - `oWE` = 1 << `cnt`[A_BIT+1:A_BIT],
    - `oADDR_WR` = `cnt`[A_BIT-1:0],
    - `oDATA` = `iADC_DATA`.
  - `cnt` increments on each accepted sample.
  - Sample 0 goes to bank 0 addr 0; sample N_bank goes to bank 1 addr 0; and so on.
  - The N-th accepted sample → START.
  - Gaps in `iADC_VALID` are allowed.
- **START**
  - `oFFT_START`=1 for exactly one cycle → WAIT.
  - Entered one cycle after the last `oWE`, so the final write lands before the start pulse.
- **WAIT**
  - An internal flag `seen_low` is set when `iFFT_RDY`=0 is sampled.
  - `iFFT_RDY`=1 with `seen_low` set → DUMP, `cnt`=0. A stale high RDY from the previous frame is therefore ignored.
  - The cycle counter reaching TIMEOUT → `oERR`=1, go to IDLE.
- **DUMP**
  - Each cycle, `oADDR_RD` = `cnt`[A_BIT-1:0] and `cnt` increments, for N cycles.
  - The bank index is pipelined RD_LAT cycles and used to select `iFFT_RE_x` into `oOUT_DATA`.
  - `oOUT_VALID` follows the address by RD_LAT+1 cycles (mux register).
  - Bins are emitted in storage order: index k = bank·N_bank + addr.
  - `oOUT_LAST` accompanies bin N-1.
  - After LAST → IDLE.
- **Overflow:** `iADC_VALID`=1 in any state other than LOAD sets `oOVF`. The sample is dropped; RAM is not written.
- `iARM` outside IDLE is ignored.
- No data arithmetic is performed; data is passed through unmodified (no sign extension on the write path; `fft_top` expands internally).

## Timing
- **Reset values:** every output is 0, state is IDLE, `cnt`=0, `seen_low`=0. Reset is asynchronous and can occur mid-frame.
  - An aborted LOAD leaves partial RAM contents. The next frame overwrites them fully.
  - An aborted DUMP truncates the stream without asserting `oOUT_LAST`.
- **Load cost:** the ARM→LOAD transition takes 1 cycle. With continuous valid, the frame takes N cycles, and `oFFT_START` fires 2 cycles after the N-th valid.
- **DUMP length:** N+RD_LAT+1 cycles, from the first `oADDR_RD` to `oOUT_LAST`. `oOUT_VALID` is contiguous for N cycles.
- **Counter wrap:** the all-ones value (N-1) is the terminal count in both LOAD and DUMP. `cnt` never wraps into a second frame.
- **Coincident conditions:**
  - `iADC_VALID` on the same cycle as LOAD entry is not accepted (READY is still low), so `oOVF` sets.
  - `iFFT_RDY` rising on the same cycle as timeout resolves to DUMP (RDY wins).

## Test plan
- **Single frame:** A_BIT=2 (N=16), RD_LAT=2, `iARM`, then 16 continuous samples 0..15.
  - Writes go to bank0 addr0..3 = 0..3, …, bank3 addr0..3 = 12..15.
  - One `oFFT_START` occurs 2 cycles after the last valid.
- **Throttled load:** valid on every 3rd cycle → same RAM contents, no `oOVF`, START after the 16th sample.
- **Stale RDY:** hold `iFFT_RDY`=1 through START, drop it for 5 cycles, then raise it → DUMP begins only on the second rise.
- **Readout:** model banks as RE_b[a] = 100·b+a.
  - `oOUT_DATA` = 0,1,2,3,100,…,303, with `oOUT_LAST` on 303.
  - Valid is contiguous for 16 cycles, starting 3 cycles after the first `oADDR_RD`.
- **Errors:**
  - Valid while in IDLE → `oOVF`=1; it stays set until the next `iARM`.
  - With TIMEOUT=20 and RDY never rising → `oERR`=1 and return to IDLE.
- **Reset mid-LOAD** after 7 samples → all outputs 0 immediately. A fresh `iARM` plus 16 samples completes normally.
